ram_access_ctrl: RTL and testbench
==================================

# ram_access_ctrl

Owns the address and enable lines of the 16 x 8 program/data RAM and shares the RAM between two requesters: the CPU control unit in normal execution, and an internal sequencer that either loads a program byte-by-byte from an external loader port or zero-fills all 16 locations. While the sequencer owns the RAM, the controller holds the CPU and drives the shared 8-bit bus itself. It sits between the control unit/MAR and the RAM, on the same tri-state bus.

## Interface

- ADDR_W, 4: RAM address width; depth is 2^ADDR_W = 16.
- DATA_W, 8: bus / RAM word width.

Clocking: one clock, `clk`; reset `rst` is synchronous and active-high.

- clk  in  1  system clock; all state changes on rising edge
- rst  in  1  synchronous active-high reset
- cpu_addr  in  ADDR_W  address from MAR
- cpu_wr_en  in  1  control-word RAM write (RAM takes bus)
- cpu_rd_en  in  1  control-word RAM read (RAM drives bus)
- prog_mode  in  1  level; high requests loader ownership of RAM
- clr_req  in  1  single-cycle pulse; request zero-fill of all RAM
- ld_valid  in  1  loader byte valid
- ld_data  in  DATA_W  loader byte
- ld_ready  out  1  controller accepts loader byte this cycle
- ram_addr  out  ADDR_W  to RAM address
- ram_wr_en  out  1  to RAM write enable
- ram_rd_en  out  1  to RAM read enable
- bus_drive_en  out  1  controller drives bus_out onto shared bus (tri-state enable)
- bus_out  out  DATA_W  data driven when bus_drive_en=1
- cpu_hold  out  1  stall CPU clock-enable/ring counter
- ld_ptr  out  ADDR_W  next RAM address the loader will write
- ld_wrap  out  1  one-cycle pulse when a load write hits address 15
- clr_done  out  1  one-cycle pulse after address 15 is cleared

## Operation

States: CPU, HOLD, LOAD, WRITE, CLEAR.
- CPU: ram_addr=cpu_addr, ram_wr_en=cpu_wr_en, ram_rd_en=cpu_rd_en & ~cpu_wr_en (write wins; both high never reaches RAM as a read). bus_drive_en=0, cpu_hold=0, ld_ready=0.
  - clr_req=1 -> HOLD (mode=clear). Else prog_mode=1 -> HOLD (mode=load). clr_req beats prog_mode.
- HOLD: cpu_hold=1, ram_wr_en=ram_rd_en=0, bus_drive_en=0 (one bus-turnaround cycle). ptr<=0. Next: CLEAR if mode=clear, else LOAD.
- LOAD: cpu_hold=1, ld_ready=1, RAM enables 0. ld_valid=1 -> latch ld_data into wdata, -> WRITE. Else prog_mode=0 -> CPU. ld_valid beats prog_mode=0 in same cycle.
- WRITE: ram_addr=ptr, ram_wr_en=1, bus_drive_en=1, bus_out=wdata, ld_ready=0. ptr<=ptr+1 mod 16 (15 wraps to 0; further bytes overwrite from 0). ld_wrap=1 when ptr=15. -> LOAD.
- CLEAR: ram_addr=ptr, ram_wr_en=1, bus_drive_en=1, bus_out=0. ptr<=ptr+1. At ptr=15: clr_done=1, -> CPU. clr_req/prog_mode ignored while clearing.
- clr_req outside CPU state is dropped (not queued).
- ld_ptr = ptr at all times.
- Outputs in CPU state are combinational from cpu_* inputs; all others are decoded from registered state/ptr/wdata.

## Timing

- Reset: state=CPU, ptr=0, wdata=0. While rst=1: ram_wr_en=ram_rd_en=0, bus_drive_en=0, bus_out=0, cpu_hold=0, ld_ready=0, ld_wrap=0, clr_done=0, ram_addr=0.
- Entry: request sampled at edge N in CPU -> HOLD cycle N+1 -> LOAD/CLEAR from N+2. cpu_hold rises in cycle N+1.
- Load: handshake at cycle k (ld_valid & ld_ready) -> WRITE in k+1 (RAM captures at end of k+1) -> LOAD in k+2. Peak throughput 1 byte / 2 cycles. ld_ready is never high in WRITE.
- Exit: prog_mode=0 seen in LOAD at edge M -> CPU in M+1, where cpu_hold=0 and the CPU path is live.
- Clear: 16 consecutive CLEAR cycles. Request at N -> CLEAR cycles N+2..N+17, clr_done in N+17, CPU in N+18.
- rst mid-LOAD/CLEAR: aborts next edge. RAM contents already written are kept; ptr returns to 0.

## Test plan

- Reset then CPU pass-through: cpu_addr=5, cpu_rd_en=1 -> ram_addr=5, ram_rd_en=1, cpu_hold=0. Add cpu_wr_en=1 -> ram_rd_en=0, ram_wr_en=1.
- Load 3 bytes 0xA1,0xB2,0xC3 back-to-back with ld_valid held high -> writes at addr 0,1,2 on alternate cycles, ld_ptr=3. Drop prog_mode -> CPU next cycle. CPU reads return 0xA1/0xB2/0xC3.
- Load 17 bytes 0x00..0x10 -> ld_wrap pulses on the 16th write. Addr 0 ends at 0x10, addr 1 holds 0x01.
- clr_req and prog_mode asserted in the same cycle -> CLEAR wins. 16 writes of 0x00, clr_done at request+17, then HOLD/LOAD since prog_mode is still high.
- ld_valid=1 and prog_mode=0 in the same LOAD cycle -> byte still written before return to CPU.
- rst asserted during the 3rd CLEAR cycle -> next cycle all outputs at reset values. Addr 0-1 cleared, addr 2+ unchanged.

Source files
------------

// File: rtl/ram_access_ctrl.sv
// ram_access_ctrl
// Arbitrates the 16 x 8 program/data RAM between the CPU control unit and an
// internal sequencer. The sequencer either stores loader bytes at consecutive
// addresses or zero-fills the whole RAM. While it owns the RAM, the CPU is
// held and this block drives the shared bus.
// In CPU state the RAM controls follow the cpu_* inputs combinationally.
// In every other state they are decoded from the registered state, pointer
// and write-data holding register.

module ram_access_ctrl #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic              cpu_wr_en,
    input  logic              cpu_rd_en,
    input  logic              prog_mode,
    input  logic              clr_req,
    input  logic              ld_valid,
    input  logic [DATA_W-1:0] ld_data,
    output logic              ld_ready,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_wr_en,
    output logic              ram_rd_en,
    output logic              bus_drive_en,
    output logic [DATA_W-1:0] bus_out,
    output logic              cpu_hold,
    output logic [ADDR_W-1:0] ld_ptr,
    output logic              ld_wrap,
    output logic              clr_done
);

    typedef enum logic [2:0] {
        ST_CPU   = 3'd0,
        ST_HOLD  = 3'd1,
        ST_LOAD  = 3'd2,
        ST_WRITE = 3'd3,
        ST_CLEAR = 3'd4
    } state_t;

    localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};
    localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] ADDR_LAST = {ADDR_W{1'b1}};
    localparam logic [DATA_W-1:0] DATA_ZERO = {DATA_W{1'b0}};

    state_t            state_r;
    logic [ADDR_W-1:0] ptr_r;
    logic [DATA_W-1:0] wdata_r;
    logic              mode_clr_r;   // 1: HOLD leads to CLEAR, 0: HOLD leads to LOAD

    logic              ld_ready_s;
    logic [ADDR_W-1:0] ram_addr_s;
    logic              ram_wr_en_s;
    logic              ram_rd_en_s;
    logic              bus_drive_en_s;
    logic [DATA_W-1:0] bus_out_s;
    logic              cpu_hold_s;
    logic              ld_wrap_s;
    logic              clr_done_s;

    // Ownership state machine, sequencer pointer and latched loader byte.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_CPU;
            ptr_r      <= ADDR_ZERO;
            wdata_r    <= DATA_ZERO;
            mode_clr_r <= 1'b0;
        end else begin
            case (state_r)
                ST_CPU: begin
                    // A clear request wins over a pending program-mode request.
                    if (clr_req) begin
                        state_r    <= ST_HOLD;
                        mode_clr_r <= 1'b1;
                    end else if (prog_mode) begin
                        state_r    <= ST_HOLD;
                        mode_clr_r <= 1'b0;
                    end else begin
                        state_r <= ST_CPU;
                    end
                end
                ST_HOLD: begin
                    // Bus turnaround cycle; the sequencer always starts at address 0.
                    ptr_r   <= ADDR_ZERO;
                    state_r <= mode_clr_r ? ST_CLEAR : ST_LOAD;
                end
                ST_LOAD: begin
                    // A byte offered together with prog_mode low is still stored.
                    if (ld_valid) begin
                        wdata_r <= ld_data;
                        state_r <= ST_WRITE;
                    end else if (!prog_mode) begin
                        state_r <= ST_CPU;
                    end else begin
                        state_r <= ST_LOAD;
                    end
                end
                ST_WRITE: begin
                    // Pointer wraps 15 -> 0 so further bytes overwrite from the start.
                    ptr_r   <= ptr_r + ADDR_ONE;
                    state_r <= ST_LOAD;
                end
                ST_CLEAR: begin
                    ptr_r <= ptr_r + ADDR_ONE;
                    if (ptr_r == ADDR_LAST) begin
                        state_r <= ST_CPU;
                    end else begin
                        state_r <= ST_CLEAR;
                    end
                end
                default: begin
                    state_r <= ST_CPU;
                end
            endcase
        end
    end

    // RAM, bus and handshake decode; everything is forced quiet while rst is high.
    always_comb begin
        ld_ready_s     = 1'b0;
        ram_addr_s     = ADDR_ZERO;
        ram_wr_en_s    = 1'b0;
        ram_rd_en_s    = 1'b0;
        bus_drive_en_s = 1'b0;
        bus_out_s      = DATA_ZERO;
        cpu_hold_s     = 1'b0;
        ld_wrap_s      = 1'b0;
        clr_done_s     = 1'b0;
        if (rst) begin
            cpu_hold_s = 1'b0;
        end else begin
            case (state_r)
                ST_CPU: begin
                    // Write wins: a simultaneous read strobe never reaches the RAM.
                    ram_addr_s  = cpu_addr;
                    ram_wr_en_s = cpu_wr_en;
                    ram_rd_en_s = cpu_rd_en & ~cpu_wr_en;
                end
                ST_HOLD: begin
                    cpu_hold_s = 1'b1;
                end
                ST_LOAD: begin
                    cpu_hold_s = 1'b1;
                    ld_ready_s = 1'b1;
                end
                ST_WRITE: begin
                    cpu_hold_s     = 1'b1;
                    ram_addr_s     = ptr_r;
                    ram_wr_en_s    = 1'b1;
                    bus_drive_en_s = 1'b1;
                    bus_out_s      = wdata_r;
                    ld_wrap_s      = (ptr_r == ADDR_LAST);
                end
                ST_CLEAR: begin
                    cpu_hold_s     = 1'b1;
                    ram_addr_s     = ptr_r;
                    ram_wr_en_s    = 1'b1;
                    bus_drive_en_s = 1'b1;
                    bus_out_s      = DATA_ZERO;
                    clr_done_s     = (ptr_r == ADDR_LAST);
                end
                default: begin
                    cpu_hold_s = 1'b0;
                end
            endcase
        end
    end

    assign ld_ready     = ld_ready_s;
    assign ram_addr     = ram_addr_s;
    assign ram_wr_en    = ram_wr_en_s;
    assign ram_rd_en    = ram_rd_en_s;
    assign bus_drive_en = bus_drive_en_s;
    assign bus_out      = bus_out_s;
    assign cpu_hold     = cpu_hold_s;
    assign ld_wrap      = ld_wrap_s;
    assign clr_done     = clr_done_s;
    assign ld_ptr       = ptr_r;

endmodule

// File: tb/tb_ram_access_ctrl.sv
// Testbench for ram_access_ctrl: a 16 x 8 RAM model on the shared bus, a
// session-level reference model that predicts RAM writes and read data, and
// a negedge monitor that pops and compares predictions as the DUT acts.

module tb_ram_access_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] cpu_addr;
    logic       cpu_wr_en;
    logic       cpu_rd_en;
    logic       prog_mode;
    logic       clr_req;
    logic       ld_valid;
    logic [7:0] ld_data;
    logic       ld_ready;
    logic [3:0] ram_addr;
    logic       ram_wr_en;
    logic       ram_rd_en;
    logic       bus_drive_en;
    logic [7:0] bus_out;
    logic       cpu_hold;
    logic [3:0] ld_ptr;
    logic       ld_wrap;
    logic       clr_done;

    logic [7:0] cpu_bus;   // value the CPU side puts on the bus for CPU writes
    logic [7:0] bus;
    logic [7:0] mem [16];        // RAM attached to the DUT
    logic [7:0] model_mem [16];  // expected RAM contents
    int         model_ptr;

    typedef struct {
        logic [3:0] addr;
        logic [7:0] data;
        logic [1:0] flags;   // {ld_wrap, clr_done}
    } wexp_t;
    typedef struct {
        logic [3:0] addr;
        logic [7:0] data;
    } rexp_t;

    wexp_t wr_q[$];
    rexp_t rd_q[$];
    wexp_t mon_w;
    rexp_t mon_r;

    int n_checks = 0;
    int n_pass   = 0;

    ram_access_ctrl #(.ADDR_W(4), .DATA_W(8)) dut (
        .clk(clk), .rst(rst), .cpu_addr(cpu_addr), .cpu_wr_en(cpu_wr_en),
        .cpu_rd_en(cpu_rd_en), .prog_mode(prog_mode), .clr_req(clr_req),
        .ld_valid(ld_valid), .ld_data(ld_data), .ld_ready(ld_ready),
        .ram_addr(ram_addr), .ram_wr_en(ram_wr_en), .ram_rd_en(ram_rd_en),
        .bus_drive_en(bus_drive_en), .bus_out(bus_out), .cpu_hold(cpu_hold),
        .ld_ptr(ld_ptr), .ld_wrap(ld_wrap), .clr_done(clr_done)
    );

    always #5 clk = ~clk;

    assign bus = bus_drive_en ? bus_out : cpu_bus;

    // RAM model: captures the shared bus on a write strobe.
    always @(posedge clk) begin
        if (ram_wr_en) mem[ram_addr] <= bus;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Monitor: every RAM access the DUT presents is matched against the scoreboard.
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            if (ram_wr_en) begin
                if (wr_q.size() == 0) begin
                    chk("write_was_expected", 32'd0, 32'd1);
                end else begin
                    mon_w = wr_q.pop_front();
                    chk("wr_addr", 32'(ram_addr), 32'(mon_w.addr));
                    chk("wr_data", 32'(bus), 32'(mon_w.data));
                    chk("wr_flags", 32'({ld_wrap, clr_done}), 32'(mon_w.flags));
                end
                chk("rd_wr_exclusive", 32'(ram_rd_en), 32'd0);
                chk("no_ready_while_writing", 32'(ld_ready), 32'd0);
            end else begin
                chk("pulses_idle", 32'({ld_wrap, clr_done}), 32'd0);
            end
            if (ram_rd_en) begin
                if (rd_q.size() == 0) begin
                    chk("read_was_expected", 32'd0, 32'd1);
                end else begin
                    mon_r = rd_q.pop_front();
                    chk("rd_addr", 32'(ram_addr), 32'(mon_r.addr));
                    chk("rd_data", 32'(mem[ram_addr]), 32'(mon_r.data));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_write(input logic [3:0] a, input logic [7:0] d, input logic [1:0] f);
        wexp_t w;
        w.addr = a;
        w.data = d;
        w.flags = f;
        wr_q.push_back(w);
        model_mem[a] = d;
    endtask

    task automatic cpu_read(input logic [3:0] a);
        rexp_t r;
        r.addr = a;
        r.data = model_mem[a];
        rd_q.push_back(r);
        cpu_addr = a;
        cpu_rd_en = 1'b1;
        tick();
        cpu_rd_en = 1'b0;
    endtask

    task automatic cpu_write(input logic [3:0] a, input logic [7:0] d, input bit also_rd);
        expect_write(a, d, 2'b00);
        cpu_addr = a;
        cpu_bus = d;
        cpu_wr_en = 1'b1;
        cpu_rd_en = also_rd;
        tick();
        cpu_wr_en = 1'b0;
        cpu_rd_en = 1'b0;
    endtask

    task automatic wait_ready();
        int k = 0;
        while (!ld_ready && k < 8) begin
            tick();
            k++;
        end
        if (!ld_ready) chk("ld_ready_timeout", 32'd0, 32'd1);
    endtask

    // Program-load session: bytes go to addresses 0,1,2,... modulo 16.
    task automatic load_bytes(input logic [7:0] bytes[$], input bit drop_on_last, input bit gaps);
        model_ptr = 0;
        prog_mode = 1'b1;
        tick();
        chk("hold_on_entry", 32'(cpu_hold), 32'd1);
        chk("no_ready_in_hold", 32'(ld_ready), 32'd0);
        tick();
        chk("ready_after_hold", 32'(ld_ready), 32'd1);
        chk("ptr_zero_on_entry", 32'(ld_ptr), 32'd0);
        foreach (bytes[i]) begin
            if (gaps && $urandom_range(0, 2) == 0) begin
                ld_valid = 1'b0;
                repeat ($urandom_range(1, 3)) begin
                    clr_req = ($urandom_range(0, 1) == 1);   // must be ignored here
                    tick();
                end
                clr_req = 1'b0;
            end
            ld_data = bytes[i];
            ld_valid = 1'b1;
            wait_ready();
            if (drop_on_last && i == bytes.size() - 1) prog_mode = 1'b0;
            expect_write(model_ptr[3:0], bytes[i], {model_ptr == 15, 1'b0});
            model_ptr = (model_ptr + 1) % 16;
            tick();
        end
        ld_valid = 1'b0;
        if (drop_on_last) begin
            tick();
            tick();
            chk("cpu_after_late_drop", 32'(cpu_hold), 32'd0);
        end else begin
            wait_ready();
            chk("ld_ptr_after_load", 32'(ld_ptr), 32'(model_ptr));
            prog_mode = 1'b0;
            tick();
            chk("cpu_after_exit", 32'(cpu_hold), 32'd0);
            chk("no_ready_in_cpu", 32'(ld_ready), 32'd0);
        end
    endtask

    // Zero-fill: request at edge N, CLEAR cycles N+2..N+17, CPU again at N+18.
    task automatic clear_all(input bit with_prog);
        clr_req = 1'b1;
        prog_mode = with_prog;
        tick();
        clr_req = 1'b0;
        chk("clr_hold", 32'(cpu_hold), 32'd1);
        chk("clr_hold_no_write", 32'(ram_wr_en), 32'd0);
        for (int a = 0; a < 16; a++) expect_write(4'(a), 8'h00, {1'b0, a == 15});
        tick();
        for (int c = 0; c < 16; c++) begin
            chk("clr_done_timing", 32'(clr_done), 32'(c == 15));
            tick();
        end
        chk("cpu_after_clear", 32'(cpu_hold), 32'd0);
        if (with_prog) begin
            tick();
            chk("reenter_hold", 32'(cpu_hold), 32'd1);
            tick();
            chk("reenter_load", 32'(ld_ready), 32'd1);
            prog_mode = 1'b0;
            tick();
            chk("exit_after_clear", 32'(cpu_hold), 32'd0);
        end
    endtask

    initial begin
        logic [7:0] q[$];
        for (int a = 0; a < 16; a++) begin
            mem[a] = 8'h00;
            model_mem[a] = 8'h00;
        end
        rst = 1'b1;
        cpu_addr = 4'd5;
        cpu_wr_en = 1'b1;
        cpu_rd_en = 1'b1;
        prog_mode = 1'b0;
        clr_req = 1'b0;
        ld_valid = 1'b0;
        ld_data = 8'h00;
        cpu_bus = 8'h00;
        tick();
        chk("rst_ram_addr", 32'(ram_addr), 32'd0);
        chk("rst_wr_en", 32'(ram_wr_en), 32'd0);
        chk("rst_rd_en", 32'(ram_rd_en), 32'd0);
        chk("rst_outputs_quiet", 32'({bus_drive_en, bus_out, cpu_hold, ld_ready, ld_wrap, clr_done}), 32'd0);
        chk("rst_ld_ptr", 32'(ld_ptr), 32'd0);
        tick();
        cpu_wr_en = 1'b0;
        cpu_rd_en = 1'b0;
        rst = 1'b0;
        tick();

        clear_all(1'b0);

        // CPU pass-through, then write beating read
        cpu_addr = 4'd5;
        cpu_rd_en = 1'b1;
        begin
            rexp_t r;
            r.addr = 4'd5;
            r.data = model_mem[5];
            rd_q.push_back(r);
        end
        #1;
        chk("pass_ram_addr", 32'(ram_addr), 32'd5);
        chk("pass_rd_en", 32'(ram_rd_en), 32'd1);
        chk("pass_no_hold", 32'(cpu_hold), 32'd0);
        tick();
        cpu_wr_en = 1'b1;
        cpu_bus = 8'h5A;
        expect_write(4'd5, 8'h5A, 2'b00);
        #1;
        chk("write_wins_rd", 32'(ram_rd_en), 32'd0);
        chk("write_wins_wr", 32'(ram_wr_en), 32'd1);
        tick();
        cpu_wr_en = 1'b0;
        cpu_rd_en = 1'b0;

        // Three back-to-back bytes
        q = {8'hA1, 8'hB2, 8'hC3};
        load_bytes(q, 1'b0, 1'b0);
        for (int a = 0; a < 3; a++) cpu_read(4'(a));

        // Seventeen bytes: wrap on the 16th, the 17th overwrites address 0
        q.delete();
        for (int k = 0; k < 17; k++) q.push_back(8'(k));
        load_bytes(q, 1'b0, 1'b0);
        cpu_read(4'd0);
        cpu_read(4'd1);
        cpu_read(4'd15);

        // Clear and program mode together: clear wins, then load follows
        clear_all(1'b1);

        // Byte offered in the same LOAD cycle prog_mode drops
        q = {8'h77};
        load_bytes(q, 1'b1, 1'b0);
        cpu_read(4'd0);

        // Fill with non-zero data, then reset in the 3rd CLEAR cycle
        q.delete();
        for (int k = 0; k < 16; k++) q.push_back(8'(8'h80 + k));
        load_bytes(q, 1'b0, 1'b0);
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        expect_write(4'd0, 8'h00, 2'b00);
        expect_write(4'd1, 8'h00, 2'b00);
        tick();
        tick();
        tick();
        rst = 1'b1;
        #1;
        chk("rst_mid_clear_no_wr", 32'(ram_wr_en), 32'd0);
        chk("rst_mid_clear_no_drive", 32'(bus_drive_en), 32'd0);
        tick();
        rst = 1'b0;
        #1;
        chk("after_rst_no_hold", 32'(cpu_hold), 32'd0);
        chk("after_rst_ptr", 32'(ld_ptr), 32'd0);
        chk("after_rst_quiet", 32'({ram_wr_en, bus_drive_en, ld_ready, clr_done}), 32'd0);
        for (int a = 0; a < 16; a++) cpu_read(4'(a));

        // Randomized mix of CPU accesses, load sessions and clears
        repeat (60) begin
            int op;
            op = $urandom_range(0, 9);
            if (op <= 3) begin
                cpu_read(4'($urandom_range(0, 15)));
            end else if (op <= 5) begin
                cpu_write(4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)), 1'b0);
            end else if (op == 6) begin
                cpu_write(4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)), 1'b1);
            end else if (op <= 8) begin
                q.delete();
                repeat ($urandom_range(1, 20)) q.push_back(8'($urandom_range(0, 255)));
                load_bytes(q, $urandom_range(0, 3) == 0, 1'b1);
            end else begin
                clear_all($urandom_range(0, 1) == 1);
            end
            if ($urandom_range(0, 3) == 0) tick();
        end
        for (int a = 0; a < 16; a++) cpu_read(4'(a));
        tick();

        chk("writes_all_seen", 32'(wr_q.size()), 32'd0);
        chk("reads_all_seen", 32'(rd_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
